// File: rtl/ibuffer_compact.sv
// ibuffer_compact
// ---------------------------------------------------------------------------
// Instruction buffer between fetch and decode. Each cycle one fetch group of
// FETCH_WIDTH slots may be accepted. Invalid slots and slots whose fetch epoch
// differs from cur_epoch_i are dropped. The surviving slots are packed in
// program order into a circular queue of IB_DEPTH entries. The DECODE_WIDTH
// oldest entries are presented to decode, which consumes a prefix of them.
//
// Optional feature (macro IBUFFER_COMPACT_BYPASS_EN):
//   When the buffer is empty and a group fires, kept slots are shown to
//   decode in the same cycle. Slots consumed that cycle are never written.
//   This creates a combinational fetch -> decode path.
//   Without the macro, enqueued entries become visible one cycle later.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   fe_valid_i/ready_o    fetch group handshake (ready is conservative)
//   fe_instrs_i           slot instructions, slot 0 in the LSBs
//   fe_pc_i               PC of slot 0; slot i has PC fe_pc_i + 4*i
//   fe_slot_valid_i       per-slot valid mask
//   fe_pred_npc_i         per-slot predicted next PC
//   fe_ftq_id_i           per-slot FTQ tag
//   fe_fetch_epoch_i      per-slot fetch epoch
//   cur_epoch_i           current fetch epoch; other epochs are stale
//   ibuf_valid_o          thermometer mask of occupied output slots
//   ibuf_*_o              entry fields in head order
//   ibuf_deq_cnt_i        entries decode consumes; excess is clamped
//   ibuf_count_o          registered occupancy
//   flush_i               drop all contents; same-cycle fire/dequeue ignored
// ---------------------------------------------------------------------------
module ibuffer_compact #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int IB_DEPTH     = 16,
  parameter int ILEN         = 32,
  parameter int PLEN         = 32,
  parameter int FTQ_ID_W     = 3,
  parameter int EPOCH_W      = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               fe_valid_i,
  output logic                               fe_ready_o,
  input  logic [FETCH_WIDTH*ILEN-1:0]        fe_instrs_i,
  input  logic [PLEN-1:0]                    fe_pc_i,
  input  logic [FETCH_WIDTH-1:0]             fe_slot_valid_i,
  input  logic [FETCH_WIDTH*PLEN-1:0]        fe_pred_npc_i,
  input  logic [FETCH_WIDTH*FTQ_ID_W-1:0]    fe_ftq_id_i,
  input  logic [FETCH_WIDTH*EPOCH_W-1:0]     fe_fetch_epoch_i,
  input  logic [EPOCH_W-1:0]                 cur_epoch_i,
  output logic [DECODE_WIDTH-1:0]            ibuf_valid_o,
  output logic [DECODE_WIDTH*ILEN-1:0]       ibuf_instrs_o,
  output logic [DECODE_WIDTH*PLEN-1:0]       ibuf_pcs_o,
  output logic [DECODE_WIDTH*PLEN-1:0]       ibuf_pred_npc_o,
  output logic [DECODE_WIDTH*FTQ_ID_W-1:0]   ibuf_ftq_id_o,
  output logic [DECODE_WIDTH*EPOCH_W-1:0]    ibuf_fetch_epoch_o,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]  ibuf_deq_cnt_i,
  output logic [$clog2(IB_DEPTH+1)-1:0]      ibuf_count_o,
  input  logic                               flush_i
);

  localparam int PW    = $clog2(IB_DEPTH);
  localparam int CW    = $clog2(IB_DEPTH+1);
  // Entry layout, MSB first: instr | pc | pred_npc | ftq_id | epoch
  localparam int ENT_W = ILEN + 2*PLEN + FTQ_ID_W + EPOCH_W;

  logic [PW-1:0]    head_reg, head_next;
  logic [PW-1:0]    tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;

  logic [ENT_W-1:0] entry_mem [IB_DEPTH];

  logic [FETCH_WIDTH-1:0] keep;
  logic [ENT_W-1:0]       slot_ent [FETCH_WIDTH];
  int                     slot_ofs [FETCH_WIDTH];  // position among kept slots
  int                     nkeep;
  logic                   fire;
  logic                   bypass;
  int                     nenq;
  int                     ndeq;
  int                     skip;      // kept slots consumed straight from fetch
  int                     out_cnt;   // number of valid output slots
  logic                   wr_en   [FETCH_WIDTH];
  logic [PW-1:0]          wr_addr [FETCH_WIDTH];

  // Ready only looks at registered occupancy, so it never depends on the
  // group contents or on what decode consumes this cycle.
  assign fe_ready_o   = !flush_i && (int'(count_reg) <= IB_DEPTH - FETCH_WIDTH);
  assign fire         = fe_valid_i && fe_ready_o;
  assign ibuf_count_o = count_reg;

  // Per-slot keep decision and full entry (PC derived from slot index).
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
    logic [PLEN-1:0] slot_pc;
    assign slot_pc      = fe_pc_i + PLEN'(4*gi);
    assign keep[gi]     = fe_slot_valid_i[gi] &&
                          (fe_fetch_epoch_i[gi*EPOCH_W +: EPOCH_W] == cur_epoch_i);
    assign slot_ent[gi] = {fe_instrs_i[gi*ILEN +: ILEN],
                           slot_pc,
                           fe_pred_npc_i[gi*PLEN +: PLEN],
                           fe_ftq_id_i[gi*FTQ_ID_W +: FTQ_ID_W],
                           fe_fetch_epoch_i[gi*EPOCH_W +: EPOCH_W]};
  end

  // Exclusive prefix count of kept slots gives each slot its packed offset.
  always_comb begin
    int run;
    run = 0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_ofs[i] = run;
      if (keep[i]) run = run + 1;
    end
    nkeep = run;
  end

  always_comb begin
    int stored_vis;
    nenq       = fire ? nkeep : 0;
    stored_vis = (int'(count_reg) < DECODE_WIDTH) ? int'(count_reg) : DECODE_WIDTH;
`ifdef IBUFFER_COMPACT_BYPASS_EN
    bypass     = fire && (count_reg == '0);
`else
    bypass     = 1'b0;
`endif
    out_cnt    = bypass ? ((nkeep < DECODE_WIDTH) ? nkeep : DECODE_WIDTH) : stored_vis;
    ndeq       = (int'(ibuf_deq_cnt_i) < out_cnt) ? int'(ibuf_deq_cnt_i) : out_cnt;
    // Bypassed entries that decode takes are never stored, so neither
    // pointer moves for them.
    skip       = bypass ? ndeq : 0;
    head_next  = head_reg + PW'(ndeq - skip);
    tail_next  = tail_reg + PW'(nenq - skip);
    count_next = CW'(int'(count_reg) + nenq - ndeq);
  end

  // Kept slots land at tail, tail+1, ... ; addresses wrap by truncation.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_en[i]   = fire && keep[i] && (slot_ofs[i] >= skip);
      wr_addr[i] = tail_reg + PW'(slot_ofs[i] - skip);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) entry_mem[wr_addr[i]] <= slot_ent[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Output window: slot gi shows entry head+gi (wrapping).
  for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
    logic [PW-1:0]    rd_addr;
    logic [ENT_W-1:0] ent;
    assign rd_addr = head_reg + PW'(gi);
`ifdef IBUFFER_COMPACT_BYPASS_EN
    always_comb begin
      ent = entry_mem[rd_addr];
      if (bypass) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (keep[i] && slot_ofs[i] == gi) ent = slot_ent[i];
        end
      end
    end
`else
    assign ent = entry_mem[rd_addr];
`endif
    assign ibuf_valid_o[gi]                              = (gi < out_cnt);
    assign ibuf_instrs_o[gi*ILEN +: ILEN]                = ent[ENT_W-1 -: ILEN];
    assign ibuf_pcs_o[gi*PLEN +: PLEN]                   = ent[PLEN+FTQ_ID_W+EPOCH_W +: PLEN];
    assign ibuf_pred_npc_o[gi*PLEN +: PLEN]              = ent[FTQ_ID_W+EPOCH_W +: PLEN];
    assign ibuf_ftq_id_o[gi*FTQ_ID_W +: FTQ_ID_W]        = ent[EPOCH_W +: FTQ_ID_W];
    assign ibuf_fetch_epoch_o[gi*EPOCH_W +: EPOCH_W]     = ent[EPOCH_W-1:0];
  end

endmodule

// File: tb/tb_ibuffer_compact.sv
// tb_ibuffer_compact
// ---------------------------------------------------------------------------
// Self-checking bench for ibuffer_compact (default parameters). The driver
// keeps a queue-based reference model of the buffer. Each cycle it pushes the
// expected status (count, ready, number of visible entries) and the entries
// decode should consume into scoreboards. A separate monitor pops and
// compares them at the falling edge. Honours IBUFFER_COMPACT_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_ibuffer_compact;
  localparam int FW = 4, DW = 4, D = 16, ILEN = 32, PLEN = 32, FTW = 3, EW = 3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [2:0]  ftq;
    logic [2:0]  ep;
  } ent_t;

  typedef struct {
    int   cnt;
    logic rdy;
    int   vis;
  } stat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fe_valid;
  logic              fe_ready;
  logic [FW*ILEN-1:0] fe_instrs;
  logic [PLEN-1:0]   fe_pc;
  logic [FW-1:0]     fe_slot_valid;
  logic [FW*PLEN-1:0] fe_pred_npc;
  logic [FW*FTW-1:0] fe_ftq_id;
  logic [FW*EW-1:0]  fe_epoch;
  logic [EW-1:0]     cur_epoch;
  logic [DW-1:0]     ibuf_valid;
  logic [DW*ILEN-1:0] ibuf_instrs;
  logic [DW*PLEN-1:0] ibuf_pcs;
  logic [DW*PLEN-1:0] ibuf_npc;
  logic [DW*FTW-1:0] ibuf_ftq;
  logic [DW*EW-1:0]  ibuf_ep;
  logic [2:0]        deq_cnt;
  logic [4:0]        ibuf_count;
  logic              flush;

  ent_t  model_q[$];   // reference buffer contents, oldest first
  ent_t  exp_q[$];     // entries decode is expected to consume, in order
  stat_t stat_q[$];    // expected per-cycle status
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  ibuffer_compact #(
    .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .IB_DEPTH(D), .ILEN(ILEN),
    .PLEN(PLEN), .FTQ_ID_W(FTW), .EPOCH_W(EW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fe_valid_i(fe_valid), .fe_ready_o(fe_ready),
    .fe_instrs_i(fe_instrs), .fe_pc_i(fe_pc), .fe_slot_valid_i(fe_slot_valid),
    .fe_pred_npc_i(fe_pred_npc), .fe_ftq_id_i(fe_ftq_id),
    .fe_fetch_epoch_i(fe_epoch), .cur_epoch_i(cur_epoch),
    .ibuf_valid_o(ibuf_valid), .ibuf_instrs_o(ibuf_instrs), .ibuf_pcs_o(ibuf_pcs),
    .ibuf_pred_npc_o(ibuf_npc), .ibuf_ftq_id_o(ibuf_ftq),
    .ibuf_fetch_epoch_o(ibuf_ep), .ibuf_deq_cnt_i(deq_cnt),
    .ibuf_count_o(ibuf_count), .flush_i(flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; updates the reference model and scoreboards.
  task automatic drive(input logic v, input logic [FW-1:0] mask, input logic [31:0] pc,
                       input logic [FW-1:0] bad_ep, input int deq, input logic fl,
                       input logic rn, output logic fired);
    ent_t  grp[$];
    ent_t  e;
    stat_t st;
    logic [2:0] ep;
    int    nq, vis, nd;
    logic  rdy, byp;
    @(posedge clk); #1;
    ep            = 3'($urandom);
    cur_epoch     = ep;
    fe_valid      = v;
    fe_slot_valid = mask;
    fe_pc         = pc;
    deq_cnt       = 3'(deq);
    flush         = fl;
    rst_n         = rn;
    for (int i = 0; i < FW; i++) begin
      e.instr = $urandom;
      e.pc    = pc + 32'(4*i);
      e.npc   = $urandom;
      e.ftq   = 3'($urandom);
      e.ep    = bad_ep[i] ? ep + 3'd1 : ep;
      fe_instrs[i*ILEN +: ILEN]  = e.instr;
      fe_pred_npc[i*PLEN +: PLEN] = e.npc;
      fe_ftq_id[i*FTW +: FTW]    = e.ftq;
      fe_epoch[i*EW +: EW]       = e.ep;
      if (mask[i] && !bad_ep[i]) grp.push_back(e);
    end
    nq    = model_q.size();
    rdy   = !fl && (D - nq) >= FW;
    fired = v && rdy;
    if (!fired) grp.delete();
    byp = 1'b0;
`ifdef IBUFFER_COMPACT_BYPASS_EN
    byp = fired && (nq == 0);
`endif
    vis = byp ? ((grp.size() < DW) ? grp.size() : DW) : ((nq < DW) ? nq : DW);
    st.cnt = nq; st.rdy = rdy; st.vis = vis;
    stat_q.push_back(st);
    if (!rn || fl) begin
      model_q.delete();
    end else begin
      nd = (deq < vis) ? deq : vis;
      for (int k = 0; k < nd; k++) begin
        if (byp) exp_q.push_back(grp.pop_front());
        else     exp_q.push_back(model_q.pop_front());
      end
      while (grp.size() > 0) model_q.push_back(grp.pop_front());
    end
  endtask

  // Monitor: compares status every cycle and every entry decode consumes.
  initial begin
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        stat_t st;
        ent_t  e;
        logic [DW-1:0] evm;
        int n;
        st  = stat_q.pop_front();
        evm = '0;
        for (int i = 0; i < st.vis; i++) evm[i] = 1'b1;
        chk("count", 32'(ibuf_count), 32'(st.cnt));
        chk("ready", 32'(fe_ready), 32'(st.rdy));
        chk("valid_mask", 32'(ibuf_valid), 32'(evm));
        n = $countones(ibuf_valid);
        if (int'(deq_cnt) < n) n = int'(deq_cnt);
        if (!rst_n || flush) n = 0;
        for (int k = 0; k < n; k++) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_deq", 32'(ibuf_pcs[k*PLEN +: PLEN]), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("deq slot %0d pc=%h instr=%h", k, ibuf_pcs[k*PLEN +: PLEN],
                     ibuf_instrs[k*ILEN +: ILEN]);
            chk("deq_pc", ibuf_pcs[k*PLEN +: PLEN], e.pc);
            chk("deq_instr", ibuf_instrs[k*ILEN +: ILEN], e.instr);
            chk("deq_npc", ibuf_npc[k*PLEN +: PLEN], e.npc);
            chk("deq_ftq", 32'(ibuf_ftq[k*FTW +: FTW]), 32'(e.ftq));
            chk("deq_epoch", 32'(ibuf_ep[k*EW +: EW]), 32'(e.ep));
          end
        end
      end
    end
  end

  initial begin
    logic f;
    int   acc, guard;
    logic [31:0] pc;
    rst_n = 1'b0; fe_valid = 1'b0; fe_instrs = '0; fe_pc = '0; fe_slot_valid = '0;
    fe_pred_npc = '0; fe_ftq_id = '0; fe_epoch = '0; cur_epoch = '0;
    deq_cnt = '0; flush = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then a full group at 0x8000_0000 visible next cycle.
    drive(1'b1, 4'hF, 32'h8000_0000, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    // Sparse mask, then a stale epoch on slot 3.
    drive(1'b1, 4'b1010, 32'h0000_1000, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    drive(1'b1, 4'b1010, 32'h0000_2000, 4'b1000, 0, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    // Fill to 13: ready drops, returns after one dequeue; then clamp.
    drive(1'b1, 4'hF, 32'h0000_3000, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'hF, 32'h0000_3010, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'hF, 32'h0000_3020, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'b0001, 32'h0000_3030, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 7, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 0, 1'b0, 1'b1, f);

    // Stream 40 groups of 3 kept slots across pointer wrap.
    acc = 0; guard = 0; pc = 32'h0000_4000;
    while (acc < 40 && guard < 400) begin
      drive(1'b1, 4'hF & ~(4'b0001 << $urandom_range(0, 3)), pc, 4'h0,
            (acc < 20) ? 2 : 3, 1'b0, 1'b1, f);
      if (f) begin acc++; pc = pc + 32'd16; end
      guard++;
    end
    chk("stream_accepted", 32'(acc), 32'd40);
    repeat (12) drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);

    // Flush at count 9 together with an offered group.
    drive(1'b1, 4'hF, 32'h0000_5000, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'hF, 32'h0000_5010, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'b0001, 32'h0000_5020, 4'h0, 0, 1'b0, 1'b1, f);
    drive(1'b1, 4'hF, 32'h0000_6000, 4'h0, 2, 1'b1, 1'b1, f);
    drive(1'b1, 4'hF, 32'h0000_7000, 4'h0, 4, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);

    // Empty buffer, group of 4 with two consumed in its arrival cycle.
    drive(1'b1, 4'hF, 32'h0000_8000, 4'h0, 2, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);

    // Randomized traffic with occasional flush and mid-run reset.
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
            4'($urandom) & 4'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0, f);
    end
    repeat (8) drive(1'b0, 4'h0, 32'h0, 4'h0, 4, 1'b0, 1'b1, f);

    @(posedge clk); #6;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("status_drained", 32'(stat_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibuffer_compact.md
# ibuffer_compact

Parametrised successor to the fetch-group instruction buffer. It sits between the fetch/IFU and decode stages. Each cycle it accepts one fetch group of FETCH_WIDTH slots, discards invalid and stale-epoch slots, and packs the survivors in program order into a circular per-instruction queue. It presents up to DECODE_WIDTH oldest instructions to decode, which may retire any prefix of them per cycle.

## Interface
Parameters:
- FETCH_WIDTH, 4, slots per fetch group (≥1)
- DECODE_WIDTH, 4, instructions presented to decode per cycle (≥1, independent of FETCH_WIDTH)
- IB_DEPTH, 16, entries; power of two, ≥ FETCH_WIDTH + DECODE_WIDTH
- ILEN, 32, instruction width
- PLEN, 32, address width
- FTQ_ID_W, 3, FTQ tag width
- EPOCH_W, 3, fetch-epoch width

Ports:
- clk_i  in  1  clock; the single clock for the block
- rst_ni  in  1  synchronous, active-low reset
- fe_valid_i  in  1  fetch group valid
- fe_ready_o  out  1  group will be accepted
- fe_instrs_i  in  FETCH_WIDTH*ILEN  slot instructions; slot 0 in the LSBs
- fe_pc_i  in  PLEN  PC of slot 0
- fe_slot_valid_i  in  FETCH_WIDTH  per-slot valid mask
- fe_pred_npc_i  in  FETCH_WIDTH*PLEN  predicted next PC per slot
- fe_ftq_id_i  in  FETCH_WIDTH*FTQ_ID_W  FTQ tag per slot
- fe_fetch_epoch_i  in  FETCH_WIDTH*EPOCH_W  epoch per slot
- cur_epoch_i  in  EPOCH_W  current architectural fetch epoch
- ibuf_valid_o  out  DECODE_WIDTH  thermometer mask; bit i set ⇔ output slot i holds an entry
- ibuf_instrs_o / ibuf_pcs_o / ibuf_pred_npc_o / ibuf_ftq_id_o / ibuf_fetch_epoch_o  out  DECODE_WIDTH×field  head-ordered entry fields
- ibuf_deq_cnt_i  in  $clog2(DECODE_WIDTH+1)  number of entries decode consumes this cycle
- ibuf_count_o  out  $clog2(IB_DEPTH+1)  current occupancy (registered)
- flush_i  in  1  discard all contents

## Operation
- State: head/tail pointers of width $clog2(IB_DEPTH), wrapping modulo IB_DEPTH, plus the count register.
- Slot keep condition: `keep[i] = fe_slot_valid_i[i] && fe_fetch_epoch_i[i] == cur_epoch_i`. Enqueue count is `nenq = popcount(keep)` when the group fires, otherwise 0.
- Slot PC is `fe_pc_i + 4*i`, computed modulo 2^PLEN. It is stored with the entry alongside that slot's pred_npc, ftq_id and epoch.
- Kept slots are written at tail, tail+1, … in ascending slot order. A fired group with nenq = 0 writes nothing.
- ready: `fe_ready_o = !flush_i && (IB_DEPTH - count) >= FETCH_WIDTH`.
  - Conservative: independent of fe_valid_i, the mask, and any same-cycle dequeue.
  - fire = fe_valid_i && fe_ready_o.
- Output slot i shows entry head+i (wrapping). `ibuf_valid_o[i] = (i < count)`.
- Dequeue: `ndeq = min(ibuf_deq_cnt_i, popcount(ibuf_valid_o))`; any excess request is clamped. Head advances by ndeq.
- Occupancy update: count_next = count + nenq − ndeq. Simultaneous enqueue and dequeue are always legal; by construction they never overflow.
- Flush:
  - Next-cycle count, head and tail are 0.
  - Any same-cycle fire or dequeue is ignored (fe_ready_o is already 0).
- Reset (rst_ni low at a clock edge): count = 0, head = tail = 0. Storage contents are don't-care. This applies mid-operation too: all in-flight entries are lost.

## Timing
- Reset values: ibuf_valid_o = 0, ibuf_count_o = 0, fe_ready_o = 1 (unless flush_i is asserted).
  - Data outputs are don't-care whenever the matching valid bit is 0; the bench checks them only under valid.
- Enqueue-to-visible latency: 1 cycle (without bypass).
- Dequeue: takes effect at the edge; the next entries appear the following cycle.
- flush_i asserted in cycle N: ibuf_valid_o = 0 from cycle N+1. fe_ready_o is 0 in cycle N only.
- Full boundary: fe_ready_o = 0 when free < FETCH_WIDTH. It reasserts the cycle after a dequeue frees enough space.
- Wrap-around: packing and output windows both cross index IB_DEPTH−1 → 0 seamlessly.

## Configuration
- IBUFFER_COMPACT_BYPASS_EN defined:
  - When count = 0 and a group fires with no flush, kept slots drive ibuf_valid_o and the data outputs combinationally in the same cycle.
  - Only the DECODE_WIDTH oldest kept slots are shown.
  - The first ndeq kept slots are not written; the remainder is written starting at tail.
  - Creates a fetch→decode combinational path.
- Undefined: no bypass; behaviour is exactly as in Timing (1-cycle latency).

## Test plan
- Reset, then one group with FETCH_WIDTH=4, mask 4'b1111, pc 0x8000_0000, deq_cnt 0 → next cycle ibuf_valid_o = 4'b1111, pcs 0x8000_0000/04/08/0C, count = 4.
- Mask 4'b1010, all epochs equal cur_epoch_i → two entries: output slot 0 has pc+4, output slot 1 has pc+12. Then epoch of slot 3 ≠ cur_epoch_i → only pc+4 is enqueued.
- Fill to 13 of 16 → fe_ready_o = 0. deq_cnt = 1 → fe_ready_o = 1 next cycle. deq_cnt = 7 while count = 3 → clamped: count 0 and head advances by 3.
- Stream 40 groups of 3 valid slots with deq_cnt = 2 and then 3, across pointer wrap → decode receives the PC sequence in order with no loss or duplication.
- flush_i with count = 9 and a simultaneous fe fire → next cycle count = 0, ibuf_valid_o = 0, and the fired group is absent.
- With IBUFFER_COMPACT_BYPASS_EN: empty buffer, group of 4 with deq_cnt = 2 → same-cycle valid = 4'b1111, and count = 2 the next cycle holding slots 2 and 3.
